// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch front end feeding the decode/control stage. Issues word fetches to
// instruction memory, tracks the PC of every outstanding request, buffers the
// returned instructions in a small FIFO and presents the head entry (with its
// PC and opcode field) to decode. Redirects from execute flush the buffer and
// mark any still-outstanding responses as stale so they are dropped on return.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr   fetch request and word-aligned address
//   imem_gnt             memory accepts the request this cycle
//   imem_rvalid/rdata    in-order fetch response
//   redirect/redirect_pc PC change request from execute (bits [1:0] ignored)
//   instr_valid/ready    handshake towards decode
//   instr/instr_pc       instruction at FIFO head and its address
//   instr_opcode         instr[6:0]
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      instr_opcode
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Circular pointer increment for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Control state
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;

    // Storage (data only, never reset)
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0]  pcq_q        [FIFO_DEPTH];

    logic fire;      // request handshake this cycle
    logic rsp;       // legal response this cycle (rvalid with something outstanding)
    logic drop;      // response is stale and is discarded
    logic push;      // response written into the instruction FIFO
    logic pop;       // decode consumes the head entry
    logic [CNT_W:0] occupancy;

    // Low address bits of a redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request/response qualification
    always_comb begin
        // Counting outstanding requests against FIFO space guarantees every
        // response has a slot when it returns, so no response backpressure.
        occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req  = rst_n && !redirect && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        imem_addr = fetch_pc_q;
        fire      = imem_req && imem_gnt;
        // rvalid without any outstanding request is a protocol error: ignored.
        rsp       = imem_rvalid && (outstanding_q != '0);
        drop      = rsp && (redirect || (discard_q != '0));
        push      = rsp && !drop;
        pop       = instr_valid && instr_ready;
    end

    // Next-state computation
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (fire && !rsp) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!fire && rsp) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (fire) begin
            pcq_wr_d = ptr_inc(pcq_wr_q);
        end
        if (rsp) begin
            pcq_rd_d = ptr_inc(pcq_rd_q);
        end

        // Every request still in flight after a redirect belongs to the old
        // path; older discards are already part of that outstanding count.
        if (redirect) begin
            discard_d = outstanding_d;
        end else if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Flush: a same-cycle pop has already been delivered, push is
        // suppressed by drop, so the buffer simply becomes empty.
        if (redirect) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
        end
    end

    // Head presentation; zeroed while empty so nothing stale leaks out.
    always_comb begin
        instr_valid  = (count_q != '0);
        instr        = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
        instr_pc     = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
        instr_opcode = instr[6:0];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a simple in-order memory model
// of configurable latency. Inputs change on the falling edge, outputs are
// sampled 2 time units later.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  instr_opcode;

    int vectors    = 0;
    int miscompares = 0;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_opcode (instr_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    int          lat = 1;
    int          now_n = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        if (a == 32'h104) return 32'h0050_0093;
        return {a[24:0], 7'h33};
    endfunction

    always begin
        @(negedge clk);
        #1;
        now_n++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (q_due.size() > 0 && q_due[0] <= now_n) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(now_n + lat);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Holds reset for two cycles, releases it on a falling edge; returns at
    // the start of the first cycle after release (cycle 0).
    task automatic do_reset(input int l);
        @(negedge clk);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        lat         = l;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #2;
        vectors++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ctrl: req/valid got %b, want 00", {imem_req, instr_valid});
        end
        vectors++;
        if ({instr, instr_pc} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: instr/pc got %h, want 0", {instr, instr_pc});
        end
        vectors++;
        if (instr_opcode !== 7'h0) begin
            miscompares++;
            $display("FAIL reset_opcode: got %h, want 00", instr_opcode);
        end
    endtask

    task automatic test_basic();
        do_reset(1);
        #2;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL basic_first_req: got %h, want 1_00000100", {imem_req, imem_addr});
        end
        step(); #2;
        vectors++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h104, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_second_req: req/addr/valid got %h, want 1_00000104_0", {imem_req, imem_addr, instr_valid});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr, instr_opcode} !== {1'b1, 32'h100, 32'h13, 7'h13}) begin
            miscompares++;
            $display("FAIL basic_head0: got %h, want valid 1 pc 100 instr 13 op 13", {instr_valid, instr_pc, instr, instr_opcode});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr, instr_opcode} !== {1'b1, 32'h104, 32'h0050_0093, 7'h13}) begin
            miscompares++;
            $display("FAIL basic_head1: got %h, want valid 1 pc 104 instr 00500093 op 13", {instr_valid, instr_pc, instr, instr_opcode});
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        instr_ready = 1'b0;
        repeat (3) step();
        // cycles 3 and 4: FIFO full, nothing outstanding
        for (int c = 3; c <= 4; c++) begin
            #2;
            vectors++;
            if ({imem_req, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 32'h100, 32'h13}) begin
                miscompares++;
                $display("FAIL stall_hold_c%0d: req/valid/pc/instr got %h, want 0_1_100_13", c, {imem_req, instr_valid, instr_pc, instr});
            end
            step();
        end
        instr_ready = 1'b1;
        #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'h13}) begin
            miscompares++;
            $display("FAIL stall_release_head: got %h, want 1_100_13", {instr_valid, instr_pc, instr});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h104, 32'h0050_0093, 1'b1, 32'h108}) begin
            miscompares++;
            $display("FAIL stall_second: got %h, want 1_104_00500093_1_108", {instr_valid, instr_pc, instr, imem_req, imem_addr});
        end
        step();
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h108, 32'h0000_8433}) begin
            miscompares++;
            $display("FAIL stall_third: got %h, want 1_108_00008433", {instr_valid, instr_pc, instr});
        end
    endtask

    task automatic test_reset_midop();
        do_reset(1);
        instr_ready = 1'b0;
        repeat (3) step();
        #2;
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_prefill: valid got %b, want 1", instr_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({imem_req, instr_valid, instr, instr_pc} !== {2'b00, 64'h0}) begin
            miscompares++;
            $display("FAIL midop_reset: got %h, want all zero", {imem_req, instr_valid, instr, instr_pc});
        end
        step();
    endtask

    task automatic test_gnt_backpressure();
        do_reset(1);
        #2;
        for (int c = 1; c <= 3; c++) begin
            step();
            imem_gnt = 1'b0;
            #2;
            vectors++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin
                miscompares++;
                $display("FAIL gnt_hold_c%0d: req/addr got %h, want 1_00000104", c, {imem_req, imem_addr});
            end
        end
        step();
        imem_gnt = 1'b1;
        #2;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin
            miscompares++;
            $display("FAIL gnt_regrant: got %h, want 1_00000104", {imem_req, imem_addr});
        end
        step(); #2;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
            miscompares++;
            $display("FAIL gnt_advance: got %h, want 1_00000108", {imem_req, imem_addr});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h104, 32'h0050_0093}) begin
            miscompares++;
            $display("FAIL gnt_data: got %h, want 1_104_00500093", {instr_valid, instr_pc, instr});
        end
    endtask

    // Waits (bounded) for imem_req, then checks the address.
    task automatic expect_next_req(input string name, input logic [31:0] want);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1;
                break;
            end
            step(); #2;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: no request within 20 cycles, want addr %h", name, want);
        end else if (imem_addr !== want) begin
            miscompares++;
            $display("FAIL %s: addr got %h, want %h", name, imem_addr, want);
        end
    endtask

    // Waits (bounded) for instr_valid, then checks the head entry.
    task automatic expect_next_instr(input string name, input logic [31:0] want_pc, input logic [31:0] want_instr);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                seen = 1;
                break;
            end
            step(); #2;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: no valid instr within 20 cycles, want pc %h", name, want_pc);
        end else if ({instr_pc, instr} !== {want_pc, want_instr}) begin
            miscompares++;
            $display("FAIL %s: pc/instr got %h/%h, want %h/%h", name, instr_pc, instr, want_pc, want_instr);
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(3);
        #2;
        step(); #2;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #2;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_req_low: got %b, want 0", imem_req);
        end
        step();
        redirect = 1'b0;
        #2;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flushed: valid got %b, want 0", instr_valid);
        end
        expect_next_req("redir_new_addr", 32'h0000_0200);
        expect_next_instr("redir_first_instr", 32'h0000_0200, 32'h0001_0033);
    endtask

    task automatic test_redirect_same_cycle();
        do_reset(1);
        #2;
        step(); #2;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'h13}) begin
            miscompares++;
            $display("FAIL same_pop_delivered: got %h, want 1_100_13", {instr_valid, instr_pc, instr});
        end
        step();
        redirect = 1'b0;
        #2;
        vectors++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            miscompares++;
            $display("FAIL same_after: valid/req/addr got %h, want 0_1_00000300", {instr_valid, imem_req, imem_addr});
        end
        expect_next_instr("same_first_instr", 32'h0000_0300, 32'h0001_8033);
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        #2;
        step(); #2;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        redirect_pc = 32'h0000_0501;
        step();
        redirect = 1'b0;
        #2;
        expect_next_req("b2b_new_addr", 32'h0000_0500);
        expect_next_instr("b2b_first_instr", 32'h0000_0500, 32'h0002_8033);
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #2;
        step();
        redirect = 1'b0;
        #2;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_first: got %h, want 1_fffffffc", {imem_req, imem_addr});
        end
        step(); #2;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_second: got %h, want 1_00000000", {imem_req, imem_addr});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FE33}) begin
            miscompares++;
            $display("FAIL wrap_instr0: got %h, want 1_fffffffc_fffffe33", {instr_valid, instr_pc, instr});
        end
        step(); #2;
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h33}) begin
            miscompares++;
            $display("FAIL wrap_instr1: got %h, want 1_00000000_00000033", {instr_valid, instr_pc, instr});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_reset_midop();
        test_gnt_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
